var_deshift: RTL and testbench

Serial-in, parallel-out frame collector: the receive-side counterpart of the variable shifter `var_shift`. It accepts a programmable-length bit stream (1..32 bits), MSB-first or LSB-first, one bit per accepted cycle. It assembles the bits into a right-justified 32-bit word and presents that word on a one-entry valid/ready output buffer. It sits between a serial source and word-wide datapath logic in the shifter subsystem.

---
 rtl/var_shift_pkg.sv | 19 +
 rtl/var_deshift.sv | 152 +++++++++++++++
 tb/tb_var_deshift.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/var_shift_pkg.sv
// rtl/var_shift_pkg.sv - shared types and constants for the variable shifter subsystem
//
// Purpose: common definitions used by var_shift (transmit) and var_deshift
// (receive): the deshifter FSM state type, serial bit-order constants and
// the default word width.
package var_shift_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } deshift_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/var_deshift.sv
// rtl/var_deshift.sv - serial-in parallel-out frame collector with one-entry output buffer
//
// Purpose: collects a 1..WIDTH bit serial frame (MSB- or LSB-first), right-justifies
// it and presents it on a valid/ready output buffer.
// Optional feature macro: VAR_DESHIFT_PARITY_EN (one trailing even-parity bit per frame).
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   synchronous active-high reset
//   start      in   begin a frame (IDLE only); latches len and dir
//   len        in   frame length, 0 or >WIDTH means WIDTH
//   dir        in   0 = MSB-first, 1 = LSB-first
//   sin        in   serial data bit
//   sin_valid  in   sin qualifier
//   sin_ready  out  bit accepted when sin_valid & sin_ready (SHIFT only)
//   busy       out  frame in progress (SHIFT or DONE)
//   q          out  assembled right-justified word
//   q_valid    out  q holds an unconsumed word
//   q_ready    in   consumer takes q when q_valid & q_ready
//   q_perr     out  parity error for q (0 without parity feature)
module var_deshift
  import var_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_perr
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  deshift_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_r;
  logic             dir_r;
  logic [WIDTH-1:0] shreg;

  logic [CNT_W-1:0] len_eff;
  logic             last_bit;
  logic             data_bit;
  logic [WIDTH-1:0] q_just;

  assign len_eff = ((len == '0) || (len > WIDTH_C)) ? WIDTH_C : len;

`ifdef VAR_DESHIFT_PARITY_EN
  logic par;
  // The bit at count == len_r is the trailing parity bit: it closes the
  // frame and feeds the parity accumulator but is never shifted in.
  assign last_bit = (cnt == len_r);
  assign data_bit = (cnt != len_r);
`else
  assign last_bit = (cnt == len_r - CNT_W'(1));
  assign data_bit = 1'b1;
`endif

  // LSB-first bits enter at the top, so a short frame sits left-justified
  // in shreg and has to be moved down to bit 0.
  assign q_just = (dir_r == DIR_LSB_FIRST) ? (shreg >> (WIDTH_C - len_r)) : shreg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      len_r     <= '0;
      dir_r     <= DIR_MSB_FIRST;
      shreg     <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      q_perr    <= 1'b0;
      sin_ready <= 1'b0;
      busy      <= 1'b0;
`ifdef VAR_DESHIFT_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      // Consumption; a reload from DONE below overrides this in the same cycle.
      if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            len_r     <= len_eff;
            dir_r     <= dir;
            shreg     <= '0;
            cnt       <= '0;
            sin_ready <= 1'b1;
            busy      <= 1'b1;
`ifdef VAR_DESHIFT_PARITY_EN
            par       <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (sin_valid && sin_ready) begin
            cnt <= cnt + CNT_W'(1);
            if (data_bit) begin
              if (dir_r == DIR_LSB_FIRST) begin
                shreg <= {sin, shreg[WIDTH-1:1]};
              end else begin
                shreg <= {shreg[WIDTH-2:0], sin};
              end
            end
`ifdef VAR_DESHIFT_PARITY_EN
            par <= par ^ sin;
`endif
            if (last_bit) begin
              state     <= DONE;
              sin_ready <= 1'b0;
            end
          end
        end

        DONE: begin
          if (!q_valid || q_ready) begin
            q       <= q_just;
            q_valid <= 1'b1;
`ifdef VAR_DESHIFT_PARITY_EN
            q_perr  <= par;
`else
            q_perr  <= 1'b0;
`endif
            state   <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          sin_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_var_deshift.sv
// tb/tb_var_deshift.sv - self-checking bench for var_deshift
module tb_var_deshift;

`ifdef VAR_DESHIFT_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  len = '0;
  logic        dir = 1'b0;
  logic        sin = 1'b0;
  logic        sin_valid = 1'b0;
  logic        sin_ready;
  logic        busy;
  logic [31:0] q;
  logic        q_valid;
  logic        q_ready = 1'b1;
  logic        q_perr;

  int vectors = 0;
  int errs = 0;

  var_deshift dut (
    .clk(clk), .clr(clr), .start(start), .len(len), .dir(dir),
    .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready), .busy(busy),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .q_perr(q_perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > 32) ? 32 : l;
  endfunction

  // Reference: whatever the bit order, the collected word is the low L bits of the data.
  function automatic logic [31:0] exp_word(input logic [31:0] d, input int l);
    int n = eff_len(l);
    logic [31:0] m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    return d & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int l, input logic d);
    start     = 1'b1;
    len       = l[5:0];
    dir       = d;
    sin_valid = 1'($urandom % 2);  // a bit offered with start must be dropped
    sin       = 1'($urandom % 2);
    tick();
    start     = 1'b0;
    sin_valid = 1'b0;
    check("start_sin_ready", {31'd0, sin_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
  endtask

  // Sends up to nsend bits of the frame (plus parity bit when enabled).
  task automatic send_bits(input logic [31:0] data, input int l, input logic d, input int nsend,
                           input bit gaps, input bit poke_start, input bit pflip);
    int n = eff_len(l);
    int total = n + PAR;
    int sent = 0;
    int cyc = 0;
    while (sent < nsend && sent < total) begin
      if (gaps && (cyc % 3 == 2)) begin
        sin_valid = 1'b0;
        sin = 1'($urandom % 2);
      end else begin
        sin_valid = 1'b1;
        if (sent < n) sin = d ? data[sent] : data[n-1-sent];
        else          sin = (^exp_word(data, l)) ^ pflip;
      end
      if (poke_start && sent == 2) begin
        start = 1'b1; len = 6'd3; dir = ~d;
      end else begin
        start = 1'b0;
      end
      if (sin_valid) check("bit_sin_ready", {31'd0, sin_ready}, 32'd1);
      tick();
      if (sin_valid) sent++;
      cyc++;
      if (cyc > 400) begin
        vectors++; errs++;
        $error("FAIL send_timeout observed=%0d expected=%0d", sent, total);
        break;
      end
    end
    sin_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_check(input logic [31:0] expq, input logic expperr);
    check("done_sin_ready", {31'd0, sin_ready}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_qv_not_yet", {31'd0, q_valid}, 32'd0);
    tick();
    check("q", q, expq);
    check("q_valid", {31'd0, q_valid}, 32'd1);
    check("q_perr", {31'd0, q_perr}, {31'd0, expperr});
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic full_frame(input logic [31:0] data, input int l, input logic d,
                            input bit gaps, input bit poke, input bit pflip);
    start_frame(l, d);
    send_bits(data, l, d, 64, gaps, poke, pflip);
    finish_check(exp_word(data, l), (PAR != 0) ? pflip : 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q"}, q, 32'd0);
    check({tag, "_q_valid"}, {31'd0, q_valid}, 32'd0);
    check({tag, "_q_perr"}, {31'd0, q_perr}, 32'd0);
    check({tag, "_sin_ready"}, {31'd0, sin_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          rl;
    logic        rdir;

    // Reset state
    tick(); tick();
    clr = 1'b0;
    check_all_zero("reset");

    // Idle bits are dropped
    sin_valid = 1'b1; sin = 1'b1; tick(); tick(); sin_valid = 1'b0;
    check("idle_sin_ready", {31'd0, sin_ready}, 32'd0);

    // MSB-first full width
    full_frame(32'h7105C1A6, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("consumed_q_valid", {31'd0, q_valid}, 32'd0);

    // LSB-first, 12 bits, with input gaps
    full_frame(32'h000005A6, 12, 1'b1, 1'b1, 1'b0, 1'b0);

    // len=0 and len=40 both mean 32; start mid-frame ignored
    full_frame(32'hDEADBEEF, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    full_frame(32'h13579BDF, 40, 1'b0, 1'b1, 1'b0, 1'b0);
    full_frame(32'h000000B5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    full_frame(32'h0000C3A5, 16, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure: two 4-bit frames with q_ready low
    tick();
    q_ready = 1'b0;
    full_frame(32'hA, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    start_frame(4, 1'b0);
    send_bits(32'h5, 4, 1'b0, 64, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_q", q, 32'hA);
      check("stall_q_valid", {31'd0, q_valid}, 32'd1);
    end
    q_ready = 1'b1;
    tick();
    check("reload_q", q, 32'h5);
    check("reload_q_valid", {31'd0, q_valid}, 32'd1);
    check("reload_busy", {31'd0, busy}, 32'd0);
    tick();
    check("reload_drain", {31'd0, q_valid}, 32'd0);

    // Reset mid-frame after 7 of 16 bits
    start_frame(16, 1'b0);
    send_bits(32'h0000FFFF, 16, 1'b0, 7, 1'b0, 1'b0, 1'b0);
    clr = 1'b1; tick(); clr = 1'b0;
    check_all_zero("clr_mid");
    full_frame(32'h00001234, 16, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in DONE with a full buffer
    tick();
    q_ready = 1'b0;
    full_frame(32'h0000005C, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    start_frame(5, 1'b1);
    send_bits(32'h00000013, 5, 1'b1, 64, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_clr_busy", {31'd0, busy}, 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    check_all_zero("clr_done");
    q_ready = 1'b1;
    full_frame(32'h00000001, 1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef VAR_DESHIFT_PARITY_EN
    full_frame(32'h00000081, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    full_frame(32'h00000081, 8, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      rd   = $urandom;
      rl   = int'($urandom % 64);
      rdir = 1'($urandom % 2);
      full_frame(rd, rl, rdir, 1'($urandom % 2), 1'b0, 1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
